// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a drain-then-halt sequence.
//
// Drives the instruction ROM address (pc) and fills the IF/ID slot
// (ifid_pc / ifid_valid). A fetched HALT opcode freezes pc and lets the
// downstream stages empty for DRAIN_CYCLES non-stalled cycles before the
// machine reports halted. A redirect during that window cancels the halt.
//
// Parameters:
//   RESET_PC     - pc value loaded on reset
//   PC_STEP      - pc increment per fetched instruction
//   DRAIN_CYCLES - non-stalled cycles allowed after a HALT fetch
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   begin fetching at start_addr (IDLE/HALTED only)
//   start_addr    in   first fetch address
//   stall         in   hazard hold from decode
//   redirect      in   taken branch / jump from execute
//   redirect_addr in   branch / jump target
//   rom_opcode    in   opcode returned by the ROM for the current pc
//   pc            out  fetch address to the ROM
//   ifid_pc       out  pc of the instruction in the IF/ID slot
//   ifid_valid    out  IF/ID slot holds a live instruction
//   halted        out  HALT has drained, machine stopped
//   busy          out  RUN or DRAIN
//   fetch_count   out  (FETCH_PERF_EN only) saturating count of IF/ID loads
//
// Optional feature macro: FETCH_PERF_EN
module fetch_unit #(
  parameter logic [15:0] RESET_PC     = 16'd0,
  parameter int unsigned PC_STEP      = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  input  logic [3:0]  rom_opcode,
  output logic [15:0] pc,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic        busy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      ifid_pc_q, ifid_pc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_load;   // IF/ID slot loaded with a live instruction
  logic             start_acc;    // start accepted this cycle

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    cnt_d        = cnt_q;
    fetch_load   = 1'b0;
    start_acc    = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        ifid_valid_d = 1'b0;
        if (start) begin
          pc_d      = start_addr;
          state_d   = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (redirect) begin
          pc_d         = redirect_addr;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          fetch_load   = 1'b1;
          if (rom_opcode == OP_HALT) begin
            // pc stays on the HALT so nothing past it is fetched
            cnt_d   = CNT_W'(DRAIN_CYCLES);
            state_d = DRAIN;
          end else begin
            pc_d = pc_q + 16'(PC_STEP);
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d         = redirect_addr;
          ifid_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = RUN;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
          // the decrement to zero and the move to HALTED share one edge
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc         = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == HALTED);
  assign busy       = (state_q == RUN) || (state_q == DRAIN);

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (start_acc) begin
      fetch_count_q <= '0;
    end else if (fetch_load && (fetch_count_q != '1)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  logic unused_start_acc;
  logic unused_fetch_load;
  assign unused_start_acc  = start_acc;
  assign unused_fetch_load = fetch_load;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC  = 16'h0000;
  localparam int          PSTEP   = 2;
  localparam int          DRAIN   = 3;
  localparam logic [3:0]  OP_HALT = 4'b1110;
  localparam logic [3:0]  OP_NOP  = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic [3:0]  rom_opcode = OP_NOP;
  logic [15:0] pc, ifid_pc;
  logic        ifid_valid, halted, busy;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  fetch_unit #(
    .RESET_PC    (RST_PC),
    .PC_STEP     (PSTEP),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .rom_opcode   (rom_opcode),
    .pc           (pc),
    .ifid_pc      (ifid_pc),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .busy         (busy)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALTED} mmode_t;
  mmode_t      m_mode;
  logic [15:0] m_pc, m_ipc;
  logic        m_vld;
  int          m_left;
  int          m_fc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic m_reset();
    m_mode = M_IDLE; m_pc = RST_PC; m_ipc = '0; m_vld = 1'b0; m_left = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    if (m_mode == M_IDLE || m_mode == M_HALTED) begin
      if (start) begin
        m_pc = start_addr; m_vld = 1'b0; m_mode = M_RUN; m_fc = 0;
      end
    end else if (redirect) begin
      m_pc = redirect_addr; m_vld = 1'b0; m_mode = M_RUN; m_left = 0;
    end else if (!stall) begin
      if (m_mode == M_RUN) begin
        m_ipc = m_pc; m_vld = 1'b1;
        if (m_fc < 65535) m_fc++;
        if (rom_opcode == OP_HALT) begin
          m_left = DRAIN; m_mode = M_DRAIN;
        end else begin
          m_pc = 16'((int'(m_pc) + PSTEP) % 65536);
        end
      end else begin
        m_vld = 1'b0;
        m_left--;
        if (m_left <= 0) begin
          m_left = 0; m_mode = M_HALTED;
        end
      end
    end
  endtask

  function automatic logic [50:0] obs();
`ifdef FETCH_PERF_EN
    return {pc, ifid_pc, ifid_valid, halted, busy, fetch_count};
`else
    return {pc, ifid_pc, ifid_valid, halted, busy, 16'h0000};
`endif
  endfunction

  function automatic logic [50:0] expv();
    logic [15:0] fc;
`ifdef FETCH_PERF_EN
    fc = 16'(m_fc);
`else
    fc = 16'h0000;
`endif
    return {m_pc, m_ipc, m_vld, (m_mode == M_HALTED), (m_mode == M_RUN || m_mode == M_DRAIN), fc};
  endfunction

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic st, input logic [15:0] sa, input logic sl,
                      input logic rd, input logic [15:0] ra, input logic [3:0] op);
    start = st; start_addr = sa; stall = sl; redirect = rd; redirect_addr = ra; rom_opcode = op;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({pc, ifid_pc, ifid_valid, halted, busy} !== {RST_PC, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got pc=%h ifid_pc=%h v=%b h=%b b=%b, want pc=%h 0000 0 0 0",
               pc, ifid_pc, ifid_valid, halted, busy, RST_PC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (obs() !== expv()) begin
      n_err++;
      $display("FAIL reset_idle_hold: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_sequence();
    step(1'b1, 16'd50, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (pc !== 16'd50 || ifid_valid !== 1'b0 || busy !== 1'b1 || obs() !== expv()) begin
      n_err++;
      $display("FAIL start_load: got pc=%0d v=%b b=%b, want pc=50 v=0 b=1", pc, ifid_valid, busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
      n_cmp++;
      if (pc !== 16'(52 + 2*i) || ifid_pc !== 16'(50 + 2*i) || ifid_valid !== 1'b1 || obs() !== expv()) begin
        n_err++;
        $display("FAIL seq_fetch[%0d]: got pc=%0d ifid_pc=%0d v=%b, want pc=%0d ifid_pc=%0d v=1",
                 i, pc, ifid_pc, ifid_valid, 52 + 2*i, 50 + 2*i);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, OP_NOP);
      n_cmp++;
      if (pc !== 16'd60 || ifid_pc !== 16'd58 || ifid_valid !== 1'b1 || obs() !== expv()) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got pc=%0d ifid_pc=%0d v=%b, want 60 58 1", i, pc, ifid_pc, ifid_valid);
      end
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (pc !== 16'd62 || ifid_pc !== 16'd60 || obs() !== expv()) begin
      n_err++;
      $display("FAIL stall_resume: got pc=%0d ifid_pc=%0d, want 62 60", pc, ifid_pc);
    end
  endtask

  task automatic test_redirect_stall();
    int guard = 0;
    while (m_pc != 16'd170 && guard < 100) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
      guard++;
    end
    n_cmp++;
    if (pc !== 16'd170) begin
      n_err++;
      $display("FAIL reach_170: got pc=%0d want 170", pc);
    end
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'd152, OP_NOP);
    n_cmp++;
    if (pc !== 16'd152 || ifid_valid !== 1'b0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL redirect_flush: got pc=%0d v=%b, want 152 0", pc, ifid_valid);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (ifid_pc !== 16'd152 || ifid_valid !== 1'b1 || pc !== 16'd154 || obs() !== expv()) begin
      n_err++;
      $display("FAIL redirect_refetch: got ifid_pc=%0d v=%b pc=%0d, want 152 1 154", ifid_pc, ifid_valid, pc);
    end
  endtask

  task automatic test_halt();
    int guard = 0;
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'd210, OP_NOP);
    while (m_pc != 16'd218 && guard < 20) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
      guard++;
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_HALT);
    n_cmp++;
    if (ifid_pc !== 16'd218 || ifid_valid !== 1'b1 || pc !== 16'd218 || busy !== 1'b1 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL halt_fetch: got ifid_pc=%0d v=%b pc=%0d b=%b h=%b, want 218 1 218 1 0",
               ifid_pc, ifid_valid, pc, busy, halted);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, OP_HALT);
    n_cmp++;
    if (ifid_valid !== 1'b1 || halted !== 1'b0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL drain_stall_hold: got v=%b h=%b, want 1 0", ifid_valid, halted);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_HALT);
      n_cmp++;
      if (halted !== (k == 2) || busy !== (k != 2) || ifid_valid !== 1'b0 || pc !== 16'd218) begin
        n_err++;
        $display("FAIL drain_count[%0d]: got h=%b b=%b v=%b pc=%0d, want h=%b b=%b v=0 pc=218",
                 k, halted, busy, ifid_valid, pc, k == 2, k != 2);
      end
    end
    step(1'b1, 16'd300, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (pc !== 16'd300 || halted !== 1'b0 || busy !== 1'b1 || obs() !== expv()) begin
      n_err++;
      $display("FAIL restart: got pc=%0d h=%b b=%b, want 300 0 1", pc, halted, busy);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (ifid_pc !== 16'd300 || ifid_valid !== 1'b1 || obs() !== expv()) begin
      n_err++;
      $display("FAIL restart_fetch: got ifid_pc=%0d v=%b, want 300 1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_drain_redirect();
    int guard = 0;
    while (m_pc != 16'd310 && guard < 20) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
      guard++;
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_HALT);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_HALT);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'd102, OP_HALT);
    n_cmp++;
    if (pc !== 16'd102 || halted !== 1'b0 || busy !== 1'b1 || ifid_valid !== 1'b0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL drain_redirect: got pc=%0d h=%b b=%b v=%b, want 102 0 1 0", pc, halted, busy, ifid_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    end
    n_cmp++;
    if (pc !== 16'd110 || ifid_pc !== 16'd108 || halted !== 1'b0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL drain_cancel_run: got pc=%0d ifid_pc=%0d h=%b, want 110 108 0", pc, ifid_pc, halted);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFC, OP_NOP);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (pc !== 16'h0000 || ifid_pc !== 16'hFFFE || obs() !== expv()) begin
      n_err++;
      $display("FAIL pc_wrap: got pc=%h ifid_pc=%h, want 0000 fffe", pc, ifid_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic        st, sl, rd;
      logic [15:0] sa, ra;
      logic [3:0]  op;
      st = ($urandom_range(0, 99) < 8);
      sl = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 8);
      sa = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      ra = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      op = ($urandom_range(0, 99) < 6) ? OP_HALT : 4'($urandom_range(0, 13));
      step(st, sa, sl, rd, ra, op);
      n_cmp++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'd400, 1'b0, 1'b1, 16'd400, OP_NOP);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_HALT);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_HALT);
    n_cmp++;
    if (busy !== 1'b1 || pc !== 16'd400 || obs() !== expv()) begin
      n_err++;
      $display("FAIL pre_reset_drain: got b=%b pc=%0d, want 1 400", busy, pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if ({pc, ifid_pc, ifid_valid, halted, busy} !== {RST_PC, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got pc=%h ifid_pc=%h v=%b h=%b b=%b, want %h 0000 0 0 0",
               pc, ifid_pc, ifid_valid, halted, busy, RST_PC);
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (fetch_count !== 16'h0000) begin
      n_err++;
      $display("FAIL async_reset_count: got %h want 0000", fetch_count);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 16'd500, 1'b0, 1'b0, 16'h0, OP_NOP);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, OP_NOP);
    n_cmp++;
    if (pc !== 16'd502 || ifid_pc !== 16'd500 || ifid_valid !== 1'b1 || obs() !== expv()) begin
      n_err++;
      $display("FAIL post_reset_start: got pc=%0d ifid_pc=%0d v=%b, want 502 500 1", pc, ifid_pc, ifid_valid);
    end
  endtask

  initial begin
    m_reset();
    #12;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_drain_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'd0: PC value loaded on reset.
REQ-002 SHALL provide parameter PC_STEP, default 2: PC increment per fetched instruction, since ROM entries sit at even addresses.
REQ-003 SHALL provide parameter DRAIN_CYCLES, default 3: cycles allowed after HALT fetch for downstream stages to empty.
REQ-004 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL provide port start, input, 1: begin fetching at start_addr.
REQ-007 SHALL provide port start_addr, input, 16: first fetch address.
REQ-008 SHALL provide port stall, input, 1: hazard hold from decode.
REQ-009 SHALL provide port redirect, input, 1: taken branch or jump from execute.
REQ-010 SHALL provide port redirect_addr, input, 16: branch or jump target.
REQ-011 SHALL provide port rom_opcode, input, 4: opcode returned by the instruction ROM for the current pc.
REQ-012 SHALL provide port pc, output, 16: fetch address driven to the instruction ROM.
REQ-013 SHALL provide port ifid_pc, output, 16: registered pc of the instruction in the IF/ID slot.
REQ-014 SHALL provide port ifid_valid, output, 1: the IF/ID slot holds a live instruction.
REQ-015 SHALL provide port halted, output, 1: the HALT has drained and the machine is stopped.
REQ-016 SHALL provide port busy, output, 1: high in RUN or DRAIN.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN and HALTED.
REQ-018 In IDLE or HALTED, start=1 SHALL load pc<=start_addr, set ifid_valid<=0, clear halted, and enter RUN next cycle.
REQ-019 In RUN or DRAIN, start SHALL be ignored.
REQ-020 Priority in RUN SHALL be redirect > stall > HALT detect > normal fetch.
REQ-021 On redirect in RUN, pc<=redirect_addr and ifid_valid<=0 (flush), applied one cycle after assertion, regardless of stall.
REQ-022 On stall without redirect, pc, ifid_pc and ifid_valid SHALL hold their values.
REQ-023 On normal fetch, ifid_pc<=pc, ifid_valid<=1, and pc<=pc+PC_STEP, with 16-bit wrap (16'hFFFE+2 -> 16'h0000).
REQ-024 On rom_opcode==4'b1110 (HALT) in RUN, not stalled and not redirected: ifid_pc<=pc, ifid_valid<=1, pc held, drain counter<=DRAIN_CYCLES, enter DRAIN.
REQ-025 In DRAIN, ifid_valid<=0 on each non-stalled cycle and the counter SHALL decrement only on non-stalled cycles.
REQ-026 In DRAIN, when the counter reaches 0, the block SHALL enter HALTED with halted=1.
REQ-027 Redirect in DRAIN SHALL cancel the speculative halt: pc<=redirect_addr, ifid_valid<=0, return to RUN, counter cleared.
REQ-028 In IDLE and HALTED, pc SHALL hold and ifid_valid SHALL be 0.
REQ-029 Simultaneous stall and redirect SHALL behave as redirect alone.

Reset
REQ-030 While rst_n=0, outputs SHALL immediately take: pc=RESET_PC, ifid_pc=0, ifid_valid=0, halted=0, busy=0, state=IDLE, drain counter=0; this applies mid-RUN or mid-DRAIN without waiting for clk.
REQ-031 The first state update after rst_n deasserts SHALL occur on the following rising edge.

Configuration
REQ-032 With FETCH_PERF_EN defined, the block SHALL add output fetch_count (16 bits), which increments on every cycle ifid_valid is loaded with 1 and saturates at 16'hFFFF.
REQ-033 fetch_count SHALL reset to 0 on rst_n and clear on an accepted start.
REQ-034 Without FETCH_PERF_EN, the port and counter SHALL be absent and the remaining behaviour identical.

Verification
REQ-035 Reset, then start=1 with start_addr=50 and no stall -> pc sequence 50,52,54,...; ifid_pc lags pc by one cycle; ifid_valid=1 from the second RUN cycle.
REQ-036 Stall held 3 cycles with pc=60 -> pc=60 and ifid_pc=58 for those 3 cycles; fetch resumes at 62.
REQ-037 Redirect with redirect_addr=152 while stall=1 and pc=170 -> next cycle pc=152, ifid_valid=0; the cycle after, ifid_pc=152, ifid_valid=1.
REQ-038 rom_opcode=4'b1110 at pc=218 with DRAIN_CYCLES=3 -> ifid_pc=218 valid one cycle, pc holds 218, halted=1 three non-stalled cycles later, busy=0; a following start restarts fetch.
REQ-039 Halt fetched, then redirect to 102 during DRAIN -> halted stays 0, state returns to RUN, pc=102.
REQ-040 Assert rst_n=0 mid-DRAIN -> all outputs reach reset values without a clock edge; with FETCH_PERF_EN, fetch_count=0.
